dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: word-organised storage with
// byte-lane stores and a fixed number of stall cycles per access.
// Optional out-of-range detection: define DMEM_RANGE_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEn,
  output logic [31:0] ReadData,
  output logic        MemStall,
  output logic        AccessErr
);

  localparam int AW = $clog2(DEPTH_WORDS);
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_next;

  // Access captured in the request cycle; only these are used after it.
  logic            r_wr;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;
  logic            r_oor;

  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_req;
  logic [AW-1:0]   w_idx;
  logic            w_oor;
  logic            w_cap;
  logic            w_c_wr;
  logic            w_c_rd;
  logic [AW-1:0]   w_c_idx;
  logic [31:0]     w_c_data;
  logic [3:0]      w_c_be;
  logic            w_c_oor;
  logic            w_mem_we;

  assign w_req = MemRead | MemWrite;
  assign w_idx = AW'(DataAdr >> 2);
  assign w_oor = RANGE_CHK && ((DataAdr >> (AW + 2)) != 32'd0);

  // Next state, stall request and selection of the access completing this cycle
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    MemStall   = 1'b0;
    w_cap      = 1'b0;
    w_c_wr     = 1'b0;
    w_c_rd     = 1'b0;
    w_c_idx    = r_idx;
    w_c_data   = r_wdata;
    w_c_be     = r_be;
    w_c_oor    = r_oor;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (WAIT_CYCLES == 0) begin
            // Zero-wait: the live request completes in this very cycle.
            w_c_wr   = MemWrite;
            w_c_rd   = ~MemWrite;
            w_c_idx  = w_idx;
            w_c_data = WriteData;
            w_c_be   = ByteEn;
            w_c_oor  = w_oor;
          end else begin
            MemStall = 1'b1;
            w_cap    = 1'b1;
            if (WAIT_CYCLES == 1) begin
              w_next = S_DONE;
            end else begin
              // Counter holds the WAIT cycles still to come, this one included.
              w_next     = S_WAIT;
              w_cnt_next = 4'(WAIT_CYCLES - 1);
            end
          end
        end
      end
      S_WAIT: begin
        MemStall   = 1'b1;
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_c_wr = r_wr;
        w_c_rd = ~r_wr;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_mem_we = reset & w_c_wr & ~w_c_oor;
  assign ReadData = (w_c_rd && !w_c_oor) ? r_mem[w_c_idx] : 32'd0;

  // Control state: FSM and wait counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Capture the request so later input changes have no effect
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_wr    <= MemWrite;
      r_idx   <= w_idx;
      r_wdata <= WriteData;
      r_be    <= ByteEn;
      r_oor   <= w_oor;
    end
  end

  // Byte-lane store at the closing edge of the complete cycle
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_c_be[b]) begin
          r_mem[w_c_idx][8*b +: 8] <= w_c_data[8*b +: 8];
        end
      end
    end
  end

`ifdef DMEM_RANGE_CHECK_EN
  logic r_err;

  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if ((w_c_wr | w_c_rd) & w_c_oor) begin
      r_err <= 1'b1;
    end
  end

  assign AccessErr = r_err;
`else
  assign AccessErr = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 2 and 3 wait cycles) driven
// by randomized and directed accesses, checked against a word-array model.
module tb_dmem_responder;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n    [3];
  logic        rd_s     [3];
  logic        wr_s     [3];
  logic [31:0] adr_s    [3];
  logic [31:0] wd_s     [3];
  logic [3:0]  be_s     [3];
  logic [31:0] rdata_s  [3];
  logic        stall_s  [3];
  logic        err_s    [3];

  logic [31:0] mdl   [3][64];
  logic        err_m [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WC = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(WC)) u_dut (
      .clk      (clk),
      .reset    (rst_n[g]),
      .MemRead  (rd_s[g]),
      .MemWrite (wr_s[g]),
      .DataAdr  (adr_s[g]),
      .WriteData(wd_s[g]),
      .ByteEn   (be_s[g]),
      .ReadData (rdata_s[g]),
      .MemStall (stall_s[g]),
      .AccessErr(err_s[g])
    );
  end

  function automatic int wc(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic wr, input logic rd, input logic [31:0] adr,
                       input logic [31:0] wd, input logic [3:0] be);
    wr_s[k]  = wr;
    rd_s[k]  = rd;
    adr_s[k] = adr;
    wd_s[k]  = wd;
    be_s[k]  = be;
  endtask

  // Full access: stall for wc(k) cycles, then one complete cycle, then one idle cycle.
  task automatic access(input int k, input logic wr, input logic rd, input logic [31:0] adr,
                        input logic [31:0] wd, input logic [3:0] be, output logic [31:0] obs_rd);
    int          n;
    logic [5:0]  idx;
    logic        oor;
    logic [31:0] exp_rd;
    n      = wc(k);
    idx    = adr[7:2];
    oor    = RC && (adr >= 32'd256);
    exp_rd = (wr || oor) ? 32'd0 : mdl[k][idx];
    drive(k, wr, rd, adr, wd, be);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("stall_k%0d", k), {31'd0, stall_s[k]}, 32'd1);
      chk($sformatf("rd_in_stall_k%0d", k), rdata_s[k], 32'd0);
      @(posedge clk); #1;
      drive(k, 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
    end
    // The request is held through the complete cycle; it must be consumed there.
    drive(k, wr, rd, adr, wd, be);
    @(negedge clk);
    chk($sformatf("cmpl_stall_k%0d", k), {31'd0, stall_s[k]}, 32'd0);
    chk($sformatf("cmpl_rdata_k%0d", k), rdata_s[k], exp_rd);
    obs_rd = rdata_s[k];
    @(posedge clk); #1;
    if (oor) err_m[k] = 1'b1;
    else if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[k][idx][8*b +: 8] = wd[8*b +: 8];
    end
    drive(k, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk($sformatf("idle_stall_k%0d", k), {31'd0, stall_s[k]}, 32'd0);
    chk($sformatf("idle_rdata_k%0d", k), rdata_s[k], 32'd0);
    chk($sformatf("err_k%0d", k), {31'd0, err_s[k]}, {31'd0, err_m[k]});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] old4;
    logic [31:0] adr;
    logic        wr;
    logic        rd;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0;
      err_m[k] = 1'b0;
      drive(k, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_stall_k%0d", k), {31'd0, stall_s[k]}, 32'd0);
      chk($sformatf("rst_rdata_k%0d", k), rdata_s[k], 32'd0);
      chk($sformatf("rst_err_k%0d", k), {31'd0, err_s[k]}, 32'd0);
    end
    @(posedge clk); #1;

    // Give every word a known value.
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 64; w++)
        access(k, 1'b1, 1'b0, 32'(w * 4), $urandom, 4'hF, r);

    // Store to 132 then load it back (two wait cycles).
    access(1, 1'b1, 1'b0, 32'd132, 32'hABCDE02E, 4'hF, r);
    access(1, 1'b0, 1'b1, 32'd132, 32'd0, 4'h0, r);
    chk("ld132", r, 32'hABCDE02E);

    // Partial-lane store merges with the existing word.
    access(1, 1'b1, 1'b0, 32'd40, 32'h11223344, 4'hF, r);
    access(1, 1'b1, 1'b0, 32'd40, 32'hAABBCCDD, 4'h6, r);
    access(1, 1'b0, 1'b1, 32'd40, 32'd0, 4'h0, r);
    chk("lanes40", r, 32'h11BBCC44);

    // Zero-wait back-to-back store then load.
    drive(0, 1'b1, 1'b0, 32'd8, 32'h5, 4'hF);
    @(negedge clk);
    chk("b2b_st_stall", {31'd0, stall_s[0]}, 32'd0);
    chk("b2b_st_rdata", rdata_s[0], 32'd0);
    @(posedge clk); #1;
    mdl[0][2] = 32'h5;
    drive(0, 1'b0, 1'b1, 32'd8, 32'd0, 4'h0);
    @(negedge clk);
    chk("b2b_ld_stall", {31'd0, stall_s[0]}, 32'd0);
    chk("b2b_ld_rdata", rdata_s[0], 32'h5);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    // Reset in the second stall cycle aborts the store.
    old4 = mdl[2][4];
    drive(2, 1'b1, 1'b0, 32'd16, 32'hDEAD, 4'hF);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk("abort_stall2", {31'd0, stall_s[2]}, 32'd1);
    rst_n[2] = 1'b0;
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    err_m[2] = 1'b0;
    @(negedge clk);
    chk("abort_stall_after", {31'd0, stall_s[2]}, 32'd0);
    chk("abort_rdata_after", rdata_s[2], 32'd0);
    chk("abort_err_after", {31'd0, err_s[2]}, 32'd0);
    @(posedge clk); #1;
    access(2, 1'b0, 1'b1, 32'd16, 32'd0, 4'h0, r);
    chk("abort_word4", r, old4);

    // Store just past the end: wraps to word 0, or flagged and suppressed.
    old4 = mdl[1][0];
    access(1, 1'b1, 1'b0, 32'd256, 32'h12345678, 4'hF, r);
    access(1, 1'b0, 1'b1, 32'd0, 32'd0, 4'h0, r);
    chk("oor_word0", r, RC ? old4 : 32'h12345678);
    chk("oor_err", {31'd0, err_s[1]}, {31'd0, RC});

    // Both strobes high is a store.
    access(2, 1'b1, 1'b1, 32'd4, 32'h77, 4'hF, r);
    chk("both_rdata", r, 32'd0);
    access(2, 1'b0, 1'b1, 32'd4, 32'd0, 4'h0, r);
    chk("both_word1", r, 32'h77);

    // Randomized traffic on all instances.
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 60; t++) begin
        adr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
        wr  = 1'($urandom);
        rd  = wr ? 1'($urandom) : 1'b1;
        access(k, wr, rd, adr, $urandom, 4'($urandom), r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
